// File: rtl/video_stream_packer.sv
// Packs one selectable pixel source (RGB or 8-bit) into RGB, byte or binary words,
// with per-frame control, a 2-entry output buffer, drop-on-overflow and frame counting.
module video_stream_packer #(
   parameter int NUM_SRC   = 4,
   parameter int COMP_W    = 12,
   parameter int WORD_W    = 16,
   parameter int FRAME_PIX = 307200
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3*COMP_W-1:0]      rgb_data,
   input  logic                     rgb_valid,
   input  logic [(NUM_SRC-1)*8-1:0] src_data,
   input  logic [NUM_SRC-2:0]       src_valid,
   input  logic                     frame_start,
   input  logic [2:0]               sel_src,
   input  logic [1:0]               pack_mode,
   output logic [WORD_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overflow,
   output logic                     frame_done,
   output logic [15:0]              frame_count
);

   localparam int CNT_W = $clog2(FRAME_PIX + 1);
   localparam int IDX_W = $clog2(WORD_W) + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DROP} state_t;

   state_t             state_q;
   logic [2:0]         sel_q;
   logic [1:0]         mode_q;
   logic [CNT_W-1:0]   pix_cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WORD_W-1:0]  pack_q;
   logic [WORD_W-1:0]  head_q, tail_q;
   logic               head_vld_q;
   logic [1:0]         fifo_cnt_q;
   logic               overflow_q, frame_done_q;
   logic [15:0]        frame_cnt_q;
   logic               rst_meta_q, rst_q;

   // NOTE: reset asserts asynchronously but releases only after two clk edges,
   // so no flop leaves reset on a partial cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta_q <= 1'b1;
         rst_q      <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_q      <= rst_meta_q;
      end
   end

   logic              pix_valid;
   logic [7:0]        pix_r, pix_g, pix_b;
   logic              rgb_mode, bin_mode, word_full, frame_end;
   logic [IDX_W-1:0]  ppw;
   logic [WORD_W-1:0] word_d, push_word;
   logic              push_req, pop, blocked, accept;
   logic              unused_lsbs;

   assign unused_lsbs = ^rgb_data;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pix_valid = rgb_valid;
      pix_r     = rgb_data[3*COMP_W-1 -: 8];
      pix_g     = rgb_data[2*COMP_W-1 -: 8];
      pix_b     = rgb_data[COMP_W-1 -: 8];
      for (int k = 1; k < NUM_SRC; k++) begin
         if (int'(sel_q) == k) begin
            pix_valid = src_valid[k-1];
            pix_r     = src_data[8*k-1 -: 8];
            pix_g     = src_data[8*k-1 -: 8];
            pix_b     = src_data[8*k-1 -: 8];
         end
      end
   end

   always_comb begin
      rgb_mode = (mode_q == 2'd0) || (mode_q == 2'd3);
      bin_mode = (mode_q == 2'd2);
      ppw      = rgb_mode ? IDX_W'(1) : (bin_mode ? IDX_W'(WORD_W) : IDX_W'(WORD_W / 8));
      if (rgb_mode) begin
         if (WORD_W == 16) word_d = WORD_W'({1'b0, pix_r[7:3], pix_g[7:3], pix_b[7:3]});
         else              word_d = WORD_W'({8'h00, pix_r, pix_g, pix_b});
      end else if (bin_mode) begin
         word_d = pack_q | (WORD_W'(pix_r[7]) << idx_q);
      end else begin
         word_d = pack_q | (WORD_W'(pix_r) << {idx_q, 3'b000});
      end
      word_full = (idx_q + IDX_W'(1)) == ppw;
      frame_end = (pix_cnt_q + CNT_W'(1)) == CNT_W'(FRAME_PIX);
   end

   // A word completes either on its last pixel in ACTIVE or as a padded remnant in FLUSH.
   always_comb begin
      push_req  = 1'b0;
      push_word = word_d;
      if (!frame_start) begin
         if (state_q == ACTIVE && pix_valid && word_full) begin
            push_req = 1'b1;
         end else if (state_q == FLUSH && idx_q != '0) begin
            push_req  = 1'b1;
            push_word = pack_q;
         end
      end
      pop     = head_vld_q && out_ready;
      blocked = (fifo_cnt_q == 2'd2) && !pop;
      accept  = push_req && !blocked;
   end

   always_ff @(posedge clk or posedge rst_q) begin
      if (rst_q) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         mode_q       <= '0;
         pix_cnt_q    <= '0;
         idx_q        <= '0;
         pack_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         head_vld_q   <= 1'b0;
         fifo_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         frame_done_q <= 1'b0;

         case ({accept, pop})
            2'b10: begin
               if (fifo_cnt_q == 2'd0) begin
                  head_q     <= push_word;
                  head_vld_q <= 1'b1;
               end else begin
                  tail_q <= push_word;
               end
               fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end
            2'b01: begin
               if (fifo_cnt_q == 2'd2) head_q <= tail_q;
               else                    head_vld_q <= 1'b0;
               fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_q == 2'd1) begin
                  head_q <= push_word;
               end else begin
                  head_q <= tail_q;
                  tail_q <= push_word;
               end
            end
            default: ;
         endcase

         if (push_req && blocked) overflow_q <= 1'b1;

         // frame_start restarts the frame from any state, discarding any partial word.
         if (frame_start) begin
            state_q   <= ACTIVE;
            sel_q     <= sel_src;
            mode_q    <= pack_mode;
            pix_cnt_q <= '0;
            idx_q     <= '0;
            pack_q    <= '0;
         end else begin
            case (state_q)
               ACTIVE: begin
                  if (pix_valid) begin
                     if (push_req && blocked) begin
                        state_q <= DROP;
                     end else begin
                        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                        if (word_full) begin
                           idx_q  <= '0;
                           pack_q <= '0;
                        end else begin
                           idx_q  <= idx_q + IDX_W'(1);
                           pack_q <= word_d;
                        end
                        if (frame_end) state_q <= FLUSH;
                     end
                  end
               end
               FLUSH: begin
                  if (push_req) begin
                     if (blocked) begin
                        state_q <= DROP;
                     end else begin
                        idx_q  <= '0;
                        pack_q <= '0;
                     end
                  end else if (fifo_cnt_q == 2'd0) begin
                     frame_done_q <= 1'b1;
                     frame_cnt_q  <= frame_cnt_q + 16'd1;
                     state_q      <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign out_data    = head_q;
   assign out_valid   = head_vld_q;
   assign overflow    = overflow_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_video_stream_packer.sv
// Directed bench for video_stream_packer: three instances (16-bit/4 pix, 32-bit/5 pix,
// 16-bit/16 pix) share data inputs and have private frame_start strobes.
module tb_video_stream_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [35:0] rgb_data;
   logic        rgb_valid;
   logic [23:0] src_data;
   logic [2:0]  src_valid;
   logic        fs_a, fs_b, fs_c;
   logic [2:0]  sel_src;
   logic [1:0]  pack_mode;
   logic        out_ready;

   logic [15:0] da, dc;
   logic [31:0] db;
   logic        va, vb, vc, of_a, of_b, of_c, fd_a, fd_b, fd_c;
   logic [15:0] fc_a, fc_b, fc_c;

   int n_cmp = 0;
   int n_bad = 0;
   int done_a = 0, done_b = 0, done_c = 0;
   int d0;
   logic [31:0] q_a[$], q_b[$], q_c[$];

   always #5 clk = ~clk;

   video_stream_packer #(.NUM_SRC(4), .COMP_W(12), .WORD_W(16), .FRAME_PIX(4)) u_a (
      .clk(clk), .reset(reset), .rgb_data(rgb_data), .rgb_valid(rgb_valid),
      .src_data(src_data), .src_valid(src_valid), .frame_start(fs_a), .sel_src(sel_src),
      .pack_mode(pack_mode), .out_data(da), .out_valid(va), .out_ready(out_ready),
      .overflow(of_a), .frame_done(fd_a), .frame_count(fc_a));

   video_stream_packer #(.NUM_SRC(4), .COMP_W(12), .WORD_W(32), .FRAME_PIX(5)) u_b (
      .clk(clk), .reset(reset), .rgb_data(rgb_data), .rgb_valid(rgb_valid),
      .src_data(src_data), .src_valid(src_valid), .frame_start(fs_b), .sel_src(sel_src),
      .pack_mode(pack_mode), .out_data(db), .out_valid(vb), .out_ready(out_ready),
      .overflow(of_b), .frame_done(fd_b), .frame_count(fc_b));

   video_stream_packer #(.NUM_SRC(4), .COMP_W(12), .WORD_W(16), .FRAME_PIX(16)) u_c (
      .clk(clk), .reset(reset), .rgb_data(rgb_data), .rgb_valid(rgb_valid),
      .src_data(src_data), .src_valid(src_valid), .frame_start(fs_c), .sel_src(sel_src),
      .pack_mode(pack_mode), .out_data(dc), .out_valid(vc), .out_ready(out_ready),
      .overflow(of_c), .frame_done(fd_c), .frame_count(fc_c));

   // Transfers and frame_done pulses are recorded half a cycle before the edge that commits them.
   always @(negedge clk) begin
      if (va && out_ready) q_a.push_back(32'(da));
      if (vb && out_ready) q_b.push_back(db);
      if (vc && out_ready) q_c.push_back(32'(dc));
      if (fd_a) done_a++;
      if (fd_b) done_b++;
      if (fd_c) done_c++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input int which, input logic [2:0] sel, input logic [1:0] mode);
      sel_src   = sel;
      pack_mode = mode;
      fs_a = (which == 0);
      fs_b = (which == 1);
      fs_c = (which == 2);
      tick(1);
      fs_a = 1'b0;
      fs_b = 1'b0;
      fs_c = 1'b0;
   endtask

   task automatic rgb_pix(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
      rgb_data  = {r, g, b};
      rgb_valid = 1'b1;
      tick(1);
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      reset = 1'b1; rgb_data = '0; rgb_valid = 1'b0; src_data = '0; src_valid = '0;
      fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0; sel_src = '0; pack_mode = '0; out_ready = 1'b1;
      tick(3);
      check("rst_valid", 32'(va), 32'd0);
      check("rst_data", 32'(da), 32'd0);
      check("rst_ovf", 32'(of_a), 32'd0);
      check("rst_done", 32'(fd_a), 32'd0);
      check("rst_fcnt", 32'(fc_a), 32'd0);

      // frame_start on the first edge after release must be ignored
      reset = 1'b0;
      fs_a  = 1'b1;
      tick(1);
      fs_a = 1'b0;
      repeat (4) rgb_pix(12'hFFF, 12'h000, 12'h800);
      rgb_valid = 1'b0;
      tick(4);
      check("early_fs_words", 32'(q_a.size()), 32'd0);

      // RGB, 16-bit: 4 pixels of FFF/000/800
      q_a.delete(); d0 = done_a;
      start_frame(0, 3'd0, 2'd0);
      rgb_pix(12'hFFF, 12'h000, 12'h800);
      check("rgb_lat_valid", 32'(va), 32'd1);
      check("rgb_lat_data", 32'(da), 32'h7C10);
      repeat (3) rgb_pix(12'hFFF, 12'h000, 12'h800);
      rgb_valid = 1'b0;
      tick(6);
      check("rgb_nwords", 32'(q_a.size()), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("rgb_w%0d", i), at(q_a, i), 32'h7C10);
      check("rgb_done", 32'(done_a - d0), 32'd1);
      check("rgb_fcnt", 32'(fc_a), 32'd1);

      // Full buffer with simultaneous push and pop keeps every word in order
      q_a.delete();
      out_ready = 1'b0;
      start_frame(0, 3'd0, 2'd3);
      rgb_pix(12'hFFF, 12'h000, 12'h000);
      rgb_pix(12'h000, 12'hFFF, 12'h000);
      out_ready = 1'b1;
      rgb_pix(12'h000, 12'h000, 12'hFFF);
      rgb_pix(12'hFFF, 12'hFFF, 12'hFFF);
      rgb_valid = 1'b0;
      tick(6);
      check("pp_nwords", 32'(q_a.size()), 32'd4);
      check("pp_w0", at(q_a, 0), 32'h7C00);
      check("pp_w1", at(q_a, 1), 32'h03E0);
      check("pp_w2", at(q_a, 2), 32'h001F);
      check("pp_w3", at(q_a, 3), 32'h7FFF);
      check("pp_ovf", 32'(of_a), 32'd0);
      check("pp_fcnt", 32'(fc_a), 32'd2);

      // Overflow: third word with a stalled sink drops the frame
      q_a.delete(); d0 = done_a;
      out_ready = 1'b0;
      start_frame(0, 3'd1, 2'd0);
      sel_src = 3'd0;
      start_frame(0, 3'd0, 2'd0);
      repeat (4) rgb_pix(12'h000, 12'hFFF, 12'h000);
      rgb_valid = 1'b0;
      tick(4);
      check("ovf_flag", 32'(of_a), 32'd1);
      check("ovf_hold_valid", 32'(va), 32'd1);
      check("ovf_hold_data", 32'(da), 32'h03E0);
      check("ovf_no_done", 32'(done_a - d0), 32'd0);
      check("ovf_fcnt", 32'(fc_a), 32'd2);
      out_ready = 1'b1;
      tick(4);
      rgb_valid = 1'b1;
      tick(3);
      rgb_valid = 1'b0;
      tick(3);
      check("drop_drained", 32'(q_a.size()), 32'd2);
      check("drop_w0", at(q_a, 0), 32'h03E0);
      check("drop_valid", 32'(va), 32'd0);
      q_a.delete(); d0 = done_a;
      start_frame(0, 3'd0, 2'd0);
      repeat (4) rgb_pix(12'hFFF, 12'h000, 12'h800);
      rgb_valid = 1'b0;
      tick(6);
      check("rec_nwords", 32'(q_a.size()), 32'd4);
      check("rec_w0", at(q_a, 0), 32'h7C10);
      check("rec_done", 32'(done_a - d0), 32'd1);
      check("rec_fcnt", 32'(fc_a), 32'd3);
      check("rec_ovf_sticky", 32'(of_a), 32'd1);

      // Byte mode, 32-bit, source 2, 5 pixels -> one full word plus padded remnant
      q_b.delete(); d0 = done_b;
      start_frame(1, 3'd2, 2'd1);
      src_valid = 3'b010;
      for (int i = 1; i <= 5; i++) begin
         src_data = {8'h00, 8'(i), 8'h00};
         tick(1);
      end
      src_valid = '0;
      tick(6);
      check("byte_nwords", 32'(q_b.size()), 32'd2);
      check("byte_w0", at(q_b, 0), 32'h0403_0201);
      check("byte_w1", at(q_b, 1), 32'h0000_0005);
      check("byte_done", 32'(done_b - d0), 32'd1);
      check("byte_fcnt", 32'(fc_b), 32'd1);

      // Binary mode, 16-bit, source 1, alternating 80/00
      q_c.delete(); d0 = done_c;
      start_frame(2, 3'd1, 2'd2);
      src_valid = 3'b001;
      for (int i = 0; i < 16; i++) begin
         src_data = {16'h0000, ((i % 2) == 0) ? 8'h80 : 8'h00};
         tick(1);
      end
      src_valid = '0;
      tick(6);
      check("bin_nwords", 32'(q_c.size()), 32'd1);
      check("bin_w0", at(q_c, 0), 32'h5555);
      check("bin_done", 32'(done_c - d0), 32'd1);

      // Abort mid-frame and switch from source 1 to source 3
      q_b.delete(); d0 = done_b;
      start_frame(1, 3'd1, 2'd1);
      src_valid = 3'b111;
      src_data  = {8'h33, 8'h22, 8'hAA}; tick(1);
      src_data  = {8'h33, 8'h22, 8'hBB}; tick(1);
      start_frame(1, 3'd3, 2'd1);
      for (int i = 0; i < 5; i++) begin
         src_data = {8'h11 + 8'(i), 8'h22, 8'hEE};
         tick(1);
      end
      src_valid = '0;
      tick(8);
      check("abort_nwords", 32'(q_b.size()), 32'd2);
      check("abort_w0", at(q_b, 0), 32'h1413_1211);
      check("abort_w1", at(q_b, 1), 32'h0000_0015);
      check("abort_done", 32'(done_b - d0), 32'd1);
      check("abort_fcnt", 32'(fc_b), 32'd2);

      // Reset asserted mid-ACTIVE takes effect within the cycle
      out_ready = 1'b0;
      start_frame(0, 3'd0, 2'd0);
      repeat (2) rgb_pix(12'hFFF, 12'h000, 12'h800);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(va), 32'd0);
      check("mid_rst_data", 32'(da), 32'd0);
      check("mid_rst_ovf", 32'(of_a), 32'd0);
      check("mid_rst_done", 32'(fd_a), 32'd0);
      check("mid_rst_fcnt", 32'(fc_a), 32'd0);
      check("mid_rst_fcnt_b", 32'(fc_b), 32'd0);
      rgb_valid = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
